exception_sequencer: RTL and testbench
======================================

Name: exception_sequencer

Overview:
- Control-side counterpart of the status register: reads the PSW, current privilege and IE; stacks and unstacks PSW and PC through a memory handshake; writes the new or restored PSW back through the status register's full-word write port.
- Handles interrupt/exception entry (push PC, push PSW, fetch vector, load) and RETI (pop PSW, pop PC, load).
- Sits between the control unit, the status register, the PC/SP registers and the memory arbiter.

Parameters:
- WORD, 16: datapath width; multiple of 8.
- FLAGS, 4: flag bits in PSW[FLAGS-1:0].
- PLVLS, 8: privilege levels; PRIVW = $clog2(PLVLS).
- VECTORS, 16: vector table entries; VECW = $clog2(VECTORS).
- VEC_BASE, 16'hFFC0: vector table byte base address.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- irq_i  in  1  level interrupt/exception request
- irqVec_i  in  VECW  vector index
- irqPriv_i  in  PRIVW  privilege level for the handler
- irqAck_o  out  1  one-cycle pulse when a request is accepted
- reti_i  in  1  RETI request from the decoder (level, sampled in IDLE)
- busy_o  out  1  sequencer not in IDLE
- done_o  out  1  one-cycle pulse in the LOAD cycle
- psw_i  in  WORD  status register word; layout: Curr[W-1:W-PRIVW], Prev[below Curr], IE=FLAGS+1, SLP=FLAGS, flags[FLAGS-1:0]
- pc_i, sp_i  in  WORD  current PC and SP
- memReq_o  out  1  memory request
- memWr_o  out  1  1 = write, 0 = read
- memAddr_o, memWData_o  out  WORD  access address and write data
- memRData_i  in  WORD  read data, valid with memAck_i
- memAck_i  in  1  access complete
- pswWrEn_o  out  1  status register write enable
- pswWrMode_o  out  WORD/8  byte enables; always all-ones when pswWrEn_o is high
- pswData_o  out  WORD  PSW write data
- pcLd_o, pcData_o  out  1/WORD  PC load
- spLd_o, spData_o  out  1/WORD  SP load

Behaviour:
- Reset (rst_i sampled high at the clock edge): state IDLE; all outputs 0; latched values cleared. Applies mid-sequence: memReq_o drops the next cycle; an in-flight access is abandoned.
- States: IDLE, PUSH_PC, PUSH_PSW, VEC_RD, POP_PSW, POP_PC, LOAD.
- IDLE:
  - reti_i=1 -> POP_PSW. reti_i has priority over irq_i; a held irq_i is re-evaluated on the next return to IDLE.
  - else irq_i=1 and IE=1 -> irqAck_o=1 this cycle; latch pc_i, sp_i, psw_i, irqVec_i, irqPriv_i; go to PUSH_PC.
  - irq_i with IE=0 is ignored, with no output activity.
- Memory handshake:
  - memReq_o, memWr_o, memAddr_o and memWData_o are held stable until memAck_i=1 is sampled.
  - The state advances on that edge; memRData_i is captured on the same edge.
  - Back-to-back requests are allowed; there is no idle cycle between accesses.
- Entry path:
  - PUSH_PC: write latched PC to SP-2.
  - PUSH_PSW: write latched PSW to SP-4.
  - VEC_RD: read VEC_BASE + (vec<<1), which becomes the handler address.
  - LOAD (1 cycle): pcLd_o with the handler address; spLd_o with SP-4; pswWrEn_o with Curr=irqPriv, Prev=latched Curr, IE=0, SLP=0, flags preserved, reserved bits 0; done_o=1. Next state IDLE.
- Return path:
  - POP_PSW: read SP.
  - POP_PC: read SP+2.
  - LOAD: pswWrEn_o with the popped PSW verbatim; pcLd_o with the popped PC; spLd_o with SP+4; done_o=1. Next state IDLE.
- Arithmetic: all address math is modulo 2^WORD (SP and vector address wrap silently). No privilege or alignment checks.
- Latency with zero-wait memory (ack in the same cycle as req):
  - Entry: accept cycle + 3 access cycles + LOAD, so done_o comes 4 cycles after irqAck_o.
  - RETI: done_o comes 3 cycles after the IDLE cycle that sampled reti_i.
  - Each wait cycle adds 1.
- busy_o=1 in every non-IDLE state. irq_i and reti_i are ignored while busy.
- pcLd_o, spLd_o and pswWrEn_o are high only in LOAD.

Test Plan:
- Reset: pulse rst_i -> all outputs 0, busy_o=0; no memReq_o over 10 idle cycles.
- Entry, zero-wait, pc_i=0x1234, sp_i=0x0800, psw_i=0x2029, vec=3, priv=5, memory returns 0x4000 -> writes [0x07FE]=0x1234 and [0x07FC]=0x2029; read 0xFFC6; LOAD: pc=0x4000, sp=0x07FC, pswData_o=0xA409, mode=2'b11; irqAck_o pulses once; done_o 4 cycles later.
- irq_i=1 with psw_i=0x2009 (IE=0) for 20 cycles -> no irqAck_o, no memReq_o, busy_o=0.
- RETI, sp_i=0x07FC, memory returns 0x2029 then 0x1234 -> pswData_o=0x2029, pc=0x1234, sp=0x0800.
- Wait states (memAck_i delayed 3 cycles per access) -> address and data stable while waiting; entry done_o 13 cycles after irqAck_o.
- Wrap and abort: sp_i=0x0002 -> pushes to 0x0000 and 0xFFFE, new sp 0xFFFE. Simultaneous reti_i and irq_i -> RETI first, then the interrupt. rst_i during PUSH_PSW -> memReq_o=0 next cycle, state IDLE.

Source files
------------

// File: rtl/exception_sequencer.sv
// exception_sequencer: stacks PC/PSW and loads the handler on interrupt entry,
// and unstacks PSW/PC on RETI, using a req/ack memory handshake and the status
// register's full-word write port.
module exception_sequencer #(
    parameter int              WORD     = 16,
    parameter int              FLAGS    = 4,
    parameter int              PLVLS    = 8,
    parameter int              VECTORS  = 16,
    parameter logic [WORD-1:0] VEC_BASE = 16'hFFC0,
    localparam int             PRIVW    = $clog2(PLVLS),
    localparam int             VECW     = $clog2(VECTORS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              irq_i,
    input  logic [VECW-1:0]   irqVec_i,
    input  logic [PRIVW-1:0]  irqPriv_i,
    output logic              irqAck_o,
    input  logic              reti_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [WORD-1:0]   psw_i,
    input  logic [WORD-1:0]   pc_i,
    input  logic [WORD-1:0]   sp_i,
    output logic              memReq_o,
    output logic              memWr_o,
    output logic [WORD-1:0]   memAddr_o,
    output logic [WORD-1:0]   memWData_o,
    input  logic [WORD-1:0]   memRData_i,
    input  logic              memAck_i,
    output logic              pswWrEn_o,
    output logic [WORD/8-1:0] pswWrMode_o,
    output logic [WORD-1:0]   pswData_o,
    output logic              pcLd_o,
    output logic [WORD-1:0]   pcData_o,
    output logic              spLd_o,
    output logic [WORD-1:0]   spData_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PUSH_PC  = 3'd1;
    localparam logic [2:0] S_PUSH_PSW = 3'd2;
    localparam logic [2:0] S_VEC_RD   = 3'd3;
    localparam logic [2:0] S_POP_PSW  = 3'd4;
    localparam logic [2:0] S_POP_PC   = 3'd5;
    localparam logic [2:0] S_LOAD     = 3'd6;

    localparam int IE_BIT = FLAGS + 1;

    logic [2:0]       state_q;
    logic             entry_q;    // 1 = interrupt entry, 0 = RETI
    logic [WORD-1:0]  pc_q;
    logic [WORD-1:0]  sp_q;
    logic [WORD-1:0]  psw_q;
    logic [VECW-1:0]  vec_q;
    logic [PRIVW-1:0] priv_q;
    logic [WORD-1:0]  rd_psw_q;   // PSW popped on RETI
    logic [WORD-1:0]  rd_pc_q;    // handler address or popped PC

    logic             accept;
    logic [WORD-1:0]  vec_addr;
    logic [WORD-1:0]  new_psw;

    // Acceptance of an interrupt: only from IDLE, RETI wins, IE must be set.
    assign accept   = !rst_i && (state_q == S_IDLE) && !reti_i && irq_i && psw_i[IE_BIT];
    assign irqAck_o = accept;
    assign busy_o   = (state_q != S_IDLE);
    assign vec_addr = VEC_BASE + WORD'({vec_q, 1'b0});

    // Handler PSW: new privilege, previous privilege saved, IE/SLP/reserved cleared.
    always_comb begin
        new_psw                          = '0;
        new_psw[WORD-1 -: PRIVW]         = priv_q;
        new_psw[WORD-PRIVW-1 -: PRIVW]   = psw_q[WORD-1 -: PRIVW];
        new_psw[FLAGS-1:0]               = psw_q[FLAGS-1:0];
    end

    // State register and latched context; advances on memory ack.
    always_ff @(posedge clk_i) begin
        // NOTE: synchronous reset also clears the latched context so no stale
        // PC/SP/PSW can leak into a later sequence.
        if (rst_i) begin
            state_q  <= S_IDLE;
            entry_q  <= 1'b0;
            pc_q     <= '0;
            sp_q     <= '0;
            psw_q    <= '0;
            vec_q    <= '0;
            priv_q   <= '0;
            rd_psw_q <= '0;
            rd_pc_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values, independent of statement order.
            case (state_q)
                S_IDLE: begin
                    if (reti_i) begin
                        entry_q <= 1'b0;
                        sp_q    <= sp_i;
                        state_q <= S_POP_PSW;
                    end else if (accept) begin
                        entry_q <= 1'b1;
                        pc_q    <= pc_i;
                        sp_q    <= sp_i;
                        psw_q   <= psw_i;
                        vec_q   <= irqVec_i;
                        priv_q  <= irqPriv_i;
                        state_q <= S_PUSH_PC;
                    end
                end
                S_PUSH_PC:  if (memAck_i) state_q <= S_PUSH_PSW;
                S_PUSH_PSW: if (memAck_i) state_q <= S_VEC_RD;
                S_VEC_RD: begin
                    if (memAck_i) begin
                        rd_pc_q <= memRData_i;
                        state_q <= S_LOAD;
                    end
                end
                S_POP_PSW: begin
                    if (memAck_i) begin
                        rd_psw_q <= memRData_i;
                        state_q  <= S_POP_PC;
                    end
                end
                S_POP_PC: begin
                    if (memAck_i) begin
                        rd_pc_q <= memRData_i;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode: memory access per state, register loads only in LOAD.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred and
        // idle outputs read as zero.
        memReq_o    = 1'b0;
        memWr_o     = 1'b0;
        memAddr_o   = '0;
        memWData_o  = '0;
        pswWrEn_o   = 1'b0;
        pswWrMode_o = '0;
        pswData_o   = '0;
        pcLd_o      = 1'b0;
        pcData_o    = '0;
        spLd_o      = 1'b0;
        spData_o    = '0;
        done_o      = 1'b0;
        case (state_q)
            S_PUSH_PC: begin
                memReq_o   = 1'b1;
                memWr_o    = 1'b1;
                memAddr_o  = sp_q - WORD'(2);
                memWData_o = pc_q;
            end
            S_PUSH_PSW: begin
                memReq_o   = 1'b1;
                memWr_o    = 1'b1;
                memAddr_o  = sp_q - WORD'(4);
                memWData_o = psw_q;
            end
            S_VEC_RD: begin
                memReq_o  = 1'b1;
                memAddr_o = vec_addr;
            end
            S_POP_PSW: begin
                memReq_o  = 1'b1;
                memAddr_o = sp_q;
            end
            S_POP_PC: begin
                memReq_o  = 1'b1;
                memAddr_o = sp_q + WORD'(2);
            end
            S_LOAD: begin
                done_o      = 1'b1;
                pswWrEn_o   = 1'b1;
                pswWrMode_o = '1;
                pswData_o   = entry_q ? new_psw : rd_psw_q;
                pcLd_o      = 1'b1;
                pcData_o    = rd_pc_q;
                spLd_o      = 1'b1;
                spData_o    = entry_q ? (sp_q - WORD'(4)) : (sp_q + WORD'(4));
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer: directed scenarios for entry, RETI, IE masking,
// wait states, SP wrap, RETI/IRQ priority and mid-sequence reset.
module tb_exception_sequencer;

    logic        clk;
    logic        rst_i;
    logic        irq_i;
    logic [3:0]  irqVec_i;
    logic [2:0]  irqPriv_i;
    logic        irqAck_o;
    logic        reti_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] psw_i, pc_i, sp_i;
    logic        memReq_o, memWr_o;
    logic [15:0] memAddr_o, memWData_o, memRData_i;
    logic        memAck_i;
    logic        pswWrEn_o;
    logic [1:0]  pswWrMode_o;
    logic [15:0] pswData_o;
    logic        pcLd_o, spLd_o;
    logic [15:0] pcData_o, spData_o;

    int checks = 0;
    int errors = 0;

    exception_sequencer dut (
        .clk_i(clk), .rst_i(rst_i), .irq_i(irq_i), .irqVec_i(irqVec_i),
        .irqPriv_i(irqPriv_i), .irqAck_o(irqAck_o), .reti_i(reti_i),
        .busy_o(busy_o), .done_o(done_o), .psw_i(psw_i), .pc_i(pc_i), .sp_i(sp_i),
        .memReq_o(memReq_o), .memWr_o(memWr_o), .memAddr_o(memAddr_o),
        .memWData_o(memWData_o), .memRData_i(memRData_i), .memAck_i(memAck_i),
        .pswWrEn_o(pswWrEn_o), .pswWrMode_o(pswWrMode_o), .pswData_o(pswData_o),
        .pcLd_o(pcLd_o), .pcData_o(pcData_o), .spLd_o(spLd_o), .spData_o(spData_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: three programmable read locations, ack after wait_n cycles
    int          wait_n = 0;
    int          wait_cnt = 0;
    logic [15:0] rd_addr0 = 16'h0, rd_val0 = 16'h0;
    logic [15:0] rd_addr1 = 16'h0, rd_val1 = 16'h0;
    logic [15:0] rd_addr2 = 16'h0, rd_val2 = 16'h0;

    assign memAck_i   = memReq_o && (wait_cnt == wait_n);
    assign memRData_i = (memAddr_o == rd_addr0) ? rd_val0 :
                        (memAddr_o == rd_addr1) ? rd_val1 :
                        (memAddr_o == rd_addr2) ? rd_val2 : 16'hDEAD;

    always @(posedge clk) begin
        if (!memReq_o || memAck_i) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    // Monitor: cycle counter, event counts, access logs, LOAD capture, stability
    int          cyc = 0, ack_cnt = 0, done_cnt = 0, req_cnt = 0;
    int          ack_cyc = 0, done_cyc = 0, stable_err = 0, ld_err = 0;
    logic [15:0] wlog_addr[$], wlog_data[$], rlog_addr[$];
    logic [15:0] ld_pc = 0, ld_sp = 0, ld_psw = 0;
    logic [1:0]  ld_mode = 0;
    logic [2:0]  ld_en = 0;
    logic        prev_req = 0, prev_ack = 0, prev_wr = 0;
    logic [15:0] prev_addr = 0, prev_wdata = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (irqAck_o) begin ack_cnt <= ack_cnt + 1; ack_cyc <= cyc; end
        if (memReq_o) req_cnt <= req_cnt + 1;
        if (memReq_o && memAck_i) begin
            if (memWr_o) begin wlog_addr.push_back(memAddr_o); wlog_data.push_back(memWData_o); end
            else         rlog_addr.push_back(memAddr_o);
        end
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            ld_pc    <= pcData_o;
            ld_sp    <= spData_o;
            ld_psw   <= pswData_o;
            ld_mode  <= pswWrMode_o;
            ld_en    <= {pcLd_o, spLd_o, pswWrEn_o};
        end
        if ((pcLd_o || spLd_o || pswWrEn_o) && !done_o) ld_err <= ld_err + 1;
        if (memReq_o && prev_req && !prev_ack &&
            (memAddr_o != prev_addr || memWr_o != prev_wr || memWData_o != prev_wdata))
            stable_err <= stable_err + 1;
        prev_req   <= memReq_o;
        prev_ack   <= memAck_i;
        prev_wr    <= memWr_o;
        prev_addr  <= memAddr_o;
        prev_wdata <= memWData_o;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!ok) begin
                tick();
                if (done_cnt != d0) ok = 1'b1;
            end
        end
    endtask

    task automatic set_irq_ctx(input logic [15:0] pc, input logic [15:0] sp,
                               input logic [15:0] psw, input logic [3:0] vec,
                               input logic [2:0] priv);
        pc_i = pc; sp_i = sp; psw_i = psw; irqVec_i = vec; irqPriv_i = priv;
    endtask

    task automatic test_reset();
        int r0;
        rst_i = 1'b1;
        irq_i = 1'b0; reti_i = 1'b0;
        set_irq_ctx(16'h0, 16'h0, 16'h0, 4'h0, 3'h0);
        tick(); tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if ({memReq_o, memWr_o, memAddr_o, memWData_o, busy_o, done_o, irqAck_o,
             pswWrEn_o, pswWrMode_o, pswData_o, pcLd_o, pcData_o, spLd_o, spData_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b busy=%b done=%b addr=%h exp all zero",
                     memReq_o, busy_o, done_o, memAddr_o);
        end
        r0 = req_cnt;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (req_cnt !== r0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got req_cycles=%0d busy=%b exp 0 0", req_cnt - r0, busy_o);
        end
    endtask

    task automatic test_entry();
        int w0, r0, a0, d0;
        bit ok;
        tick();
        wait_n = 0;
        rd_addr2 = 16'hFFC6; rd_val2 = 16'h4000;
        set_irq_ctx(16'h1234, 16'h0800, 16'h2029, 4'd3, 3'd5);
        w0 = wlog_addr.size(); r0 = rlog_addr.size(); a0 = ack_cnt; d0 = done_cnt;
        irq_i = 1'b1;
        #1;
        checks++;
        if (irqAck_o !== 1'b1) begin errors++; $display("FAIL entry_ack got %b exp 1", irqAck_o); end
        tick();
        irq_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL entry_busy got %b exp 1", busy_o); end
        wait_done(d0, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL entry_timeout got no done exp done"); end
        checks++;
        if (wlog_addr.size() != w0 + 2 || rlog_addr.size() != r0 + 1) begin
            errors++;
            $display("FAIL entry_access_count got w=%0d r=%0d exp 2 1",
                     wlog_addr.size() - w0, rlog_addr.size() - r0);
        end else if (wlog_addr[w0] !== 16'h07FE || wlog_data[w0] !== 16'h1234 ||
                     wlog_addr[w0+1] !== 16'h07FC || wlog_data[w0+1] !== 16'h2029 ||
                     rlog_addr[r0] !== 16'hFFC6) begin
            errors++;
            $display("FAIL entry_accesses got [%h]=%h [%h]=%h rd %h exp [07fe]=1234 [07fc]=2029 rd ffc6",
                     wlog_addr[w0], wlog_data[w0], wlog_addr[w0+1], wlog_data[w0+1], rlog_addr[r0]);
        end
        checks++;
        if (ld_pc !== 16'h4000 || ld_sp !== 16'h07FC || ld_psw !== 16'hA409 ||
            ld_mode !== 2'b11 || ld_en !== 3'b111) begin
            errors++;
            $display("FAIL entry_load got pc=%h sp=%h psw=%h mode=%b en=%b exp 4000 07fc a409 11 111",
                     ld_pc, ld_sp, ld_psw, ld_mode, ld_en);
        end
        checks++;
        if (ack_cnt - a0 != 1 || done_cyc - ack_cyc != 4) begin
            errors++;
            $display("FAIL entry_latency got acks=%0d lat=%0d exp 1 4", ack_cnt - a0, done_cyc - ack_cyc);
        end
    endtask

    task automatic test_ie_masked();
        int r0, a0;
        bit bad;
        bad = 1'b0;
        tick();
        set_irq_ctx(16'h1234, 16'h0800, 16'h2009, 4'd3, 3'd5);
        r0 = req_cnt; a0 = ack_cnt;
        irq_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (irqAck_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
            tick();
        end
        irq_i = 1'b0;
        checks++;
        if (bad || req_cnt != r0 || ack_cnt != a0) begin
            errors++;
            $display("FAIL ie_masked got acks=%0d reqs=%0d busy_seen=%b exp 0 0 0",
                     ack_cnt - a0, req_cnt - r0, bad);
        end
    endtask

    task automatic test_reti();
        int w0, r0, d0, reti_cyc;
        bit ok;
        tick();
        wait_n = 0;
        sp_i = 16'h07FC;
        rd_addr0 = 16'h07FC; rd_val0 = 16'h2029;
        rd_addr1 = 16'h07FE; rd_val1 = 16'h1234;
        w0 = wlog_addr.size(); r0 = rlog_addr.size(); d0 = done_cnt;
        reti_cyc = cyc;
        reti_i = 1'b1;
        tick();
        reti_i = 1'b0;
        wait_done(d0, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reti_timeout got no done exp done"); end
        checks++;
        if (ld_psw !== 16'h2029 || ld_pc !== 16'h1234 || ld_sp !== 16'h0800 || ld_en !== 3'b111) begin
            errors++;
            $display("FAIL reti_load got psw=%h pc=%h sp=%h en=%b exp 2029 1234 0800 111",
                     ld_psw, ld_pc, ld_sp, ld_en);
        end
        checks++;
        if (rlog_addr.size() != r0 + 2 || wlog_addr.size() != w0) begin
            errors++;
            $display("FAIL reti_access_count got r=%0d w=%0d exp 2 0",
                     rlog_addr.size() - r0, wlog_addr.size() - w0);
        end else if (rlog_addr[r0] !== 16'h07FC || rlog_addr[r0+1] !== 16'h07FE) begin
            errors++;
            $display("FAIL reti_addrs got %h %h exp 07fc 07fe", rlog_addr[r0], rlog_addr[r0+1]);
        end
        checks++;
        if (done_cyc - reti_cyc != 3) begin
            errors++;
            $display("FAIL reti_latency got %0d exp 3", done_cyc - reti_cyc);
        end
    endtask

    task automatic test_wait_states();
        int d0, q0, s0;
        bit ok;
        tick();
        wait_n = 3;
        rd_addr2 = 16'hFFC6; rd_val2 = 16'h4000;
        set_irq_ctx(16'h1234, 16'h0800, 16'h2029, 4'd3, 3'd5);
        d0 = done_cnt; q0 = req_cnt; s0 = stable_err;
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        wait_done(d0, 80, ok);
        wait_n = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_timeout got no done exp done"); end
        checks++;
        if (done_cyc - ack_cyc != 13 || req_cnt - q0 != 12) begin
            errors++;
            $display("FAIL wait_latency got lat=%0d req_cycles=%0d exp 13 12",
                     done_cyc - ack_cyc, req_cnt - q0);
        end
        checks++;
        if (stable_err != s0) begin
            errors++;
            $display("FAIL wait_stable got %0d changes exp 0", stable_err - s0);
        end
        checks++;
        if (ld_pc !== 16'h4000 || ld_sp !== 16'h07FC || ld_psw !== 16'hA409) begin
            errors++;
            $display("FAIL wait_load got pc=%h sp=%h psw=%h exp 4000 07fc a409", ld_pc, ld_sp, ld_psw);
        end
    endtask

    task automatic test_wrap();
        int w0, r0, d0;
        bit ok;
        tick();
        wait_n = 0;
        rd_addr2 = 16'hFFDE; rd_val2 = 16'h1000;
        set_irq_ctx(16'h5555, 16'h0002, 16'h0020, 4'hF, 3'd7);
        w0 = wlog_addr.size(); r0 = rlog_addr.size(); d0 = done_cnt;
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        wait_done(d0, 50, ok);
        checks++;
        if (!ok || wlog_addr.size() != w0 + 2 || rlog_addr.size() != r0 + 1) begin
            errors++;
            $display("FAIL wrap_access_count got done=%b w=%0d r=%0d exp 1 2 1",
                     ok, wlog_addr.size() - w0, rlog_addr.size() - r0);
        end else if (wlog_addr[w0] !== 16'h0000 || wlog_data[w0] !== 16'h5555 ||
                     wlog_addr[w0+1] !== 16'hFFFE || wlog_data[w0+1] !== 16'h0020 ||
                     rlog_addr[r0] !== 16'hFFDE) begin
            errors++;
            $display("FAIL wrap_accesses got [%h]=%h [%h]=%h rd %h exp [0000]=5555 [fffe]=0020 rd ffde",
                     wlog_addr[w0], wlog_data[w0], wlog_addr[w0+1], wlog_data[w0+1], rlog_addr[r0]);
        end
        checks++;
        if (ld_sp !== 16'hFFFE || ld_pc !== 16'h1000 || ld_psw !== 16'hE000) begin
            errors++;
            $display("FAIL wrap_load got sp=%h pc=%h psw=%h exp fffe 1000 e000", ld_sp, ld_pc, ld_psw);
        end
    endtask

    task automatic test_reti_priority();
        int d0;
        bit ok;
        tick();
        wait_n = 0;
        rd_addr0 = 16'h07FC; rd_val0 = 16'h2029;
        rd_addr1 = 16'h07FE; rd_val1 = 16'h1234;
        rd_addr2 = 16'hFFC6; rd_val2 = 16'h4000;
        set_irq_ctx(16'h1234, 16'h07FC, 16'h2029, 4'd3, 3'd5);
        d0 = done_cnt;
        reti_i = 1'b1;
        irq_i  = 1'b1;
        #1;
        checks++;
        if (irqAck_o !== 1'b0) begin errors++; $display("FAIL prio_no_ack got %b exp 0", irqAck_o); end
        tick();
        reti_i = 1'b0;
        wait_done(d0, 50, ok);
        checks++;
        if (!ok || ld_psw !== 16'h2029 || ld_sp !== 16'h0800) begin
            errors++;
            $display("FAIL prio_reti_first got done=%b psw=%h sp=%h exp 1 2029 0800", ok, ld_psw, ld_sp);
        end
        sp_i = 16'h0800;
        #1;
        checks++;
        if (irqAck_o !== 1'b1) begin errors++; $display("FAIL prio_irq_after got %b exp 1", irqAck_o); end
        d0 = done_cnt;
        tick();
        irq_i = 1'b0;
        wait_done(d0, 50, ok);
        checks++;
        if (!ok || ld_psw !== 16'hA409 || ld_pc !== 16'h4000 || ld_sp !== 16'h07FC) begin
            errors++;
            $display("FAIL prio_irq_load got done=%b psw=%h pc=%h sp=%h exp 1 a409 4000 07fc",
                     ok, ld_psw, ld_pc, ld_sp);
        end
    endtask

    task automatic test_reset_abort();
        int d0, q0;
        bit hit;
        hit = 1'b0;
        tick();
        wait_n = 3;
        set_irq_ctx(16'h1234, 16'h0800, 16'h2029, 4'd3, 3'd5);
        d0 = done_cnt;
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!hit) begin
                if (memReq_o && memWr_o && memAddr_o == 16'h07FC) hit = 1'b1;
                else tick();
            end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL abort_reach_push_psw got no access exp [07fc] write"); end
        rst_i = 1'b1;
        tick();
        checks++;
        if (memReq_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got req=%b busy=%b exp 0 0", memReq_o, busy_o);
        end
        rst_i = 1'b0;
        wait_n = 0;
        q0 = req_cnt;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (req_cnt != q0 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_quiet got reqs=%0d dones=%0d exp 0 0", req_cnt - q0, done_cnt - d0);
        end
    endtask

    task automatic test_strobes();
        checks++;
        if (ld_err != 0) begin
            errors++;
            $display("FAIL load_strobes_outside_load got %0d exp 0", ld_err);
        end
    endtask

    initial begin
        rst_i = 1'b1; irq_i = 1'b0; reti_i = 1'b0;
        pc_i = 16'h0; sp_i = 16'h0; psw_i = 16'h0; irqVec_i = 4'h0; irqPriv_i = 3'h0;
        test_reset();
        test_entry();
        test_ie_masked();
        test_reti();
        test_wait_states();
        test_wrap();
        test_reti_priority();
        test_reset_abort();
        test_strobes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
